// File: rtl/rom_loader_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rom_loader_pkg
// Purpose  : Shared definitions for the UART ROM loader: bus width macro,
//            word width, loader and receiver state encodings.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef RegBus
`define RegBus 31:0
`endif

package rom_loader_pkg;

    localparam int c_word_w = 32;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LEN  = 2'd1,
        LD_DATA = 2'd2,
        LD_DONE = 2'd3
    } ld_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd3,
        RX_WAIT  = 3'd4
    } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx_byte
// Purpose  : 8N1 UART byte receiver, LSB first. Expects an already
//            synchronized input.
// Ports    : clk, rstn (async active-low), rx (synchronized line),
//            byte_valid (1-cycle strobe), byte_data (received byte),
//            frame_err (1-cycle strobe on a low stop bit)
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_byte
    import rom_loader_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int                 c_cnt_w   = $clog2(DIV + 1);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_div_m1  = c_cnt_w'(DIV - 1);

    rx_state_t          r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]         r_bit,   w_bit_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_ferr,  w_ferr_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                // Idle is only entered with the line high, so a low here
                // is the falling edge of a start bit.
                w_cnt_nxt = '0;
                if (!rx) w_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_cnt == c_half_m1) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    // High at mid start bit: a glitch, drop it silently.
                    w_state_nxt = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_div_m1) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {rx, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == c_div_m1) begin
                    w_cnt_nxt = '0;
                    if (rx) begin
                        w_valid_nxt = 1'b1;
                        w_state_nxt = RX_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = RX_WAIT;
                    end
                end
            end
            RX_WAIT: begin
                w_cnt_nxt = '0;
                if (rx) w_state_nxt = RX_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign byte_valid = r_valid;
    assign byte_data  = r_shift;
    assign frame_err  = r_ferr;

endmodule

`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : rom_loader
// Purpose  : Receives a 32-bit little-endian word count N over UART, then
//            N little-endian 32-bit words, and writes them to program memory
//            at word indices 0..N-1.
// Ports    : clk, rstn (async active-low), load_en (arm/abort level),
//            uart_rx (async serial in), wen/w_addr/w_data (memory write),
//            busy (LEN/DATA), done (DONE), err (sticky error)
// Revision : 1.0 - initial release
// ============================================================================
`ifndef RegBus
`define RegBus 31:0
`endif

module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200,
    parameter int MEM_NUM  = 4096
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           load_en,
    input  logic           uart_rx,
    output logic           wen,
    output logic [`RegBus] w_addr,
    output logic [`RegBus] w_data,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int                  c_div     = CLK_FREQ / BAUD;
    localparam logic [c_word_w-1:0] c_mem_num = c_word_w'(MEM_NUM);

    logic                r_rx_meta, r_rx_sync;
    logic                w_byte_valid, w_frame_err;
    logic [7:0]          w_byte;

    ld_state_t           r_state, w_state_nxt;
    logic [1:0]          r_bcnt,  w_bcnt_nxt;
    logic [c_word_w-1:0] r_wcnt,  w_wcnt_nxt;
    logic [c_word_w-1:0] r_len,   w_len_nxt;
    logic [c_word_w-1:0] r_shift, w_shift_nxt;
    logic                r_wen,   w_wen_nxt;
    logic [c_word_w-1:0] r_addr,  w_addr_nxt;
    logic [c_word_w-1:0] r_data,  w_data_nxt;
    logic                r_err,   w_err_nxt;
    logic                r_load_d;
    logic [c_word_w-1:0] w_len_word, w_data_word, w_wcnt_inc;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_rx_byte #(
        .DIV (c_div)
    ) u_rx (
        .clk        (clk),
        .rstn       (rstn),
        .rx         (r_rx_sync),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte),
        .frame_err  (w_frame_err)
    );

    // New bytes enter at the top so the first byte ends up in bits 7:0.
    assign w_len_word  = {w_byte, r_len[31:8]};
    assign w_data_word = {w_byte, r_shift[31:8]};
    assign w_wcnt_inc  = r_wcnt + c_word_w'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= LD_IDLE;
            r_bcnt   <= '0;
            r_wcnt   <= '0;
            r_len    <= '0;
            r_shift  <= '0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_err    <= 1'b0;
            r_load_d <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bcnt   <= w_bcnt_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_len    <= w_len_nxt;
            r_shift  <= w_shift_nxt;
            r_wen    <= w_wen_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_err    <= w_err_nxt;
            r_load_d <= load_en;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_wcnt_nxt  = r_wcnt;
        w_len_nxt   = r_len;
        w_shift_nxt = r_shift;
        w_wen_nxt   = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
        if (load_en && !r_load_d) w_err_nxt = 1'b0;
        case (r_state)
            LD_IDLE: begin
                if (load_en) begin
                    w_state_nxt = LD_LEN;
                    w_bcnt_nxt  = '0;
                    w_wcnt_nxt  = '0;
                    w_len_nxt   = '0;
                end
            end
            LD_LEN: begin
                if (!load_en) begin
                    w_state_nxt = LD_IDLE;
                end else if (w_byte_valid) begin
                    w_len_nxt  = w_len_word;
                    w_bcnt_nxt = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        if (w_len_word == '0) begin
                            w_state_nxt = LD_DONE;
                        end else if (w_len_word > c_mem_num) begin
                            w_err_nxt   = 1'b1;
                            w_len_nxt   = c_mem_num;
                            w_state_nxt = LD_DATA;
                        end else begin
                            w_state_nxt = LD_DATA;
                        end
                    end
                end
            end
            LD_DATA: begin
                if (!load_en) begin
                    w_state_nxt = LD_IDLE;
                end else if (w_byte_valid) begin
                    w_shift_nxt = w_data_word;
                    w_bcnt_nxt  = r_bcnt + 2'd1;
                    if (r_bcnt == 2'd3) begin
                        w_wen_nxt  = 1'b1;
                        w_addr_nxt = r_wcnt;
                        w_data_nxt = w_data_word;
                        w_wcnt_nxt = w_wcnt_inc;
                        if (w_wcnt_inc == r_len) w_state_nxt = LD_DONE;
                    end
                end
            end
            LD_DONE: begin
                if (!load_en) w_state_nxt = LD_IDLE;
            end
            default: w_state_nxt = LD_IDLE;
        endcase
        if (w_frame_err) w_err_nxt = 1'b1;
    end

    assign wen    = r_wen;
    assign w_addr = r_addr;
    assign w_data = r_data;
    assign busy   = (r_state == LD_LEN) || (r_state == LD_DATA);
    assign done   = (r_state == LD_DONE);
    assign err    = r_err;

endmodule

`default_nettype wire

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_FREQ/BAUD cycles, integer-truncated.
REQ-003 Parameter MEM_NUM, default 4096, number of 32-bit words in the target memory.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 load_en  input  1  level; 1 arms or continues a load, 0 aborts it and holds the block idle.
REQ-007 uart_rx  input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-008 wen  output  1  one-cycle write strobe to the program memory.
REQ-009 w_addr  output  32  word index (not byte address) of the current write.
REQ-010 w_data  output  32  write data, little-endian assembly of four received bytes.
REQ-011 busy  output  1  high in states LEN and DATA.
REQ-012 done  output  1  high in state DONE.
REQ-013 err  output  1  sticky; set on framing error or on length > MEM_NUM; cleared by reset or by load_en 0->1.

Function
REQ-014 uart_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use.
REQ-015 RX: a falling edge in RX idle starts a frame; at DIV/2 the line is re-sampled and a high value cancels the frame silently.
REQ-016 RX: the 8 data bits are then sampled at intervals of DIV cycles, followed by the stop bit at DIV cycles after the last data bit.
REQ-017 RX: a high stop bit yields a one-cycle byte_valid with the byte; a low stop bit sets err, discards the byte and waits for the line to return high.
REQ-018 Loader FSM states: IDLE, LEN, DATA, DONE; reset state IDLE.
REQ-019 IDLE->LEN when load_en=1; byte counter, word counter and the LEN shift register are cleared on that entry.
REQ-020 LEN: four received bytes form N, little-endian (first byte = bits 7:0).
REQ-021 After the 4th LEN byte: N=0 goes to DONE; N>MEM_NUM sets err, clamps N to MEM_NUM and goes to DATA; otherwise goes to DATA.
REQ-022 DATA: each byte shifts into w_data, first byte to bits 7:0, fourth byte to bits 31:24.
REQ-023 On the 4th byte of a word, wen SHALL pulse for exactly one cycle in the cycle after byte_valid, with w_addr = word count k (k starts at 0); k then increments.
REQ-024 When k reaches N the FSM goes to DONE in the same cycle as the last wen; bytes received after that are ignored.
REQ-025 With N clamped, every byte beyond MEM_NUM*4 is ignored and wen never addresses >= MEM_NUM.
REQ-026 DONE is held while load_en=1; load_en=0 returns the FSM to IDLE.
REQ-027 load_en=0 in LEN or DATA aborts to IDLE on the next edge; no wen is issued from that edge on, and a partial word is discarded.
REQ-028 w_addr and w_data hold their last value between strobes; they are don't-care for the memory while wen=0.
REQ-029 Throughput: one word per 40 bit periods; no back-pressure, since the memory accepts a write every cycle.

Reset
REQ-030 While rstn=0: FSM=IDLE, RX idle, wen=0, w_addr=0, w_data=0, busy=0, done=0, err=0, synchronizer flops=1.
REQ-031 A reset assertion mid-frame or mid-load SHALL abandon it immediately; no wen after release until a new load completes 4 words' bytes.

Structure
REQ-032 The shared defines file carries the loader state encodings and the word width; the existing `RegBus width macro is used for w_addr and w_data.
REQ-033 The UART receiver is one sub-module, uart_rx_byte (ports clk, rstn, rx, byte_valid, byte_data, frame_err), parameterized by DIV.

Verification
REQ-034 Use CLK_FREQ=1000000 and BAUD=100000 (DIV=10) throughout the bench.
REQ-035 Send LEN 02 00 00 00, then 78 56 34 12 EF BE AD DE -> wen at w_addr 0 with w_data 0x12345678, then at w_addr 1 with 0xDEADBEEF, then done=1 and err=0.
REQ-036 Send LEN 00 00 00 00 -> done=1 with no wen.
REQ-037 Send one frame with a low stop bit during LEN -> err=1; the byte is not counted, and the next 4 good bytes complete LEN.
REQ-038 Send LEN 0x00001001 with MEM_NUM=4096 -> err=1; exactly 4096 wens with last w_addr 4095; extra bytes cause no wen.
REQ-039 Drop load_en after 6 DATA bytes -> busy=0 next cycle and only 1 wen total; re-arm and reload 1 word -> w_addr 0.
REQ-040 Pulse rstn low mid-frame -> all outputs 0 immediately; a 3-cycle low glitch on uart_rx is rejected with no byte_valid.
